// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the CPU pipeline.
//   XLEN          - machine word width
//   NOP           - encoding loaded into the IF/ID instruction register for a bubble
//   fetch_state_e - fetch stage FSM states
//   buf_entry_t   - {pc, instr} pair held by the fetch buffer
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry FIFO of fetched {pc, instr} pairs.
//   clk, rst     - clock, asynchronous active-high reset
//   clear_i      - drop all entries (takes priority over push/pop)
//   push_i       - write push_data_i; accepted when not full or when popping
//   pop_i        - drop the head entry; ignored when empty
//   head_o       - oldest entry (meaningful only when !empty_o)
//   full_o, empty_o, count_o - occupancy status
module fetch_buf
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       push_i,
    input  buf_entry_t push_data_i,
    input  logic       pop_i,
    output buf_entry_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    buf_entry_t mem_q [2];
    buf_entry_t mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        if (clear_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 2-entry prefetch buffer feeding the IF/ID register.
//   clk, rst                 - clock, asynchronous active-high reset
//   stall_i                  - hold the IF/ID outputs, nothing pops
//   redirect_i/redirect_pc_i - taken branch/jump pulse and its target (wins over stall)
//   imem_req_o/imem_addr_o   - instruction memory read request and address
//   imem_valid_i/imem_rdata_i- memory response, one cycle after the request
//   valid_o/instr_o/pc_o     - IF/ID register contents
// Optional build macro FETCH_STATS_EN adds stall_cnt_o and bubble_cnt_o
// (saturating counts of stalled cycles and loaded bubbles).
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;

    logic            credit, req, resp_live, advance, pop, bypass, push;
    logic [1:0]      occupancy;
    buf_entry_t      resp_entry, buf_head;
    logic            buf_full, buf_empty;
    logic [1:0]      buf_count;

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_i),
        .push_i      (push),
        .push_data_i (resp_entry),
        .pop_i       (pop),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign valid_o     = valid_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_out_q;

    // Memory latency is fixed at one cycle, so at most one request is ever in
    // flight. A response arriving while the buffer is empty goes straight to
    // the IF/ID register, giving a two-cycle request-to-valid latency. The
    // in-flight tag is compared with the post-redirect epoch so a response
    // landing in the redirect cycle is already stale.
    always_comb begin
        occupancy  = buf_count + {1'b0, inflight_q};
        credit     = (occupancy < 2'd2);
        req        = (state_q != INIT) && credit && !redirect_i;
        epoch_d    = epoch_q ^ redirect_i;
        resp_live  = imem_valid_i && inflight_q && (inflight_epoch_q == epoch_d);
        resp_entry.pc    = inflight_pc_q;
        resp_entry.instr = imem_rdata_i;
        advance    = !stall_i && !redirect_i;
        pop        = advance && !buf_empty;
        bypass     = advance && buf_empty && resp_live;
        push       = resp_live && !bypass && (!buf_full || pop);

        inflight_d       = req;
        inflight_pc_d    = pc_q;
        inflight_epoch_d = epoch_q;

        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (req) begin
            pc_d = pc_q + PC_STEP;
        end

        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        if (redirect_i) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (!stall_i) begin
            if (pop) begin
                valid_d  = 1'b1;
                instr_d  = buf_head.instr;
                pc_out_d = buf_head.pc;
            end else if (bypass) begin
                valid_d  = 1'b1;
                instr_d  = resp_entry.instr;
                pc_out_d = resp_entry.pc;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP;
            end
        end

        state_d = state_q;
        if (redirect_i) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                INIT:    state_d = RUN;
                RUN:     state_d = RUN;
                FLUSH:   state_d = RUN;
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= INIT;
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            valid_q          <= 1'b0;
            instr_q          <= NOP;
            pc_out_q         <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            valid_q          <= valid_d;
            instr_q          <= instr_d;
            pc_out_q         <= pc_out_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic        bubble_load;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Bubbles come from redirects and from unstalled cycles with nothing to load.
    always_comb begin
        bubble_load  = redirect_i || (advance && !pop && !bypass);
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// The memory model echoes the request address as the instruction. Every
// issued request address is queued; each new valid_o output pops the queue
// and must match in both pc_o and instr_o. Redirect and reset empty the queue.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_VAL  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_valid_i  (imem_valid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
`ifdef FETCH_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock cycle: record this cycle's request, clock, answer it, and
    // score any newly loaded output.
    task automatic tick();
        logic        req_now;
        logic [31:0] addr_now;
        logic        was_adv;
        logic [31:0] exp_pc;
        #1;
        req_now  = imem_req_o;
        addr_now = imem_addr_o;
        was_adv  = !stall_i && !redirect_i;
        if (redirect_i) exp_q.delete();
        if (req_now) exp_q.push_back(addr_now);
        @(posedge clk);
        #1;
        imem_valid_i = req_now;
        imem_rdata_i = req_now ? addr_now : 32'hDEAD_BEEF;
        if (was_adv && valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: valid_o=1 pc_o=%h but no request pending", pc_o);
            end else begin
                exp_pc = exp_q.pop_front();
                if (pc_o !== exp_pc) begin
                    errors++;
                    $display("[TB] FAIL sb_pc: got %h expected %h", pc_o, exp_pc);
                end
                checks++;
                if (instr_o !== exp_pc) begin
                    errors++;
                    $display("[TB] FAIL sb_instr: got %h expected %h", instr_o, exp_pc);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
        checks++;
        if (exp_q.size() > 2) begin
            errors++;
            $display("[TB] FAIL sb_backlog: %0d requests pending, expected at most 2", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", valid_o); end
        checks++;
        if (instr_o !== NOP_VAL) begin errors++; $display("[TB] FAIL rst_instr: got %h expected %h", instr_o, NOP_VAL); end
        checks++;
        if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h expected 0", pc_o); end
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req_o); end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL init_req: got %b expected 0", imem_req_o); end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL seq_addr: got req=%b addr=%h expected req=1 addr=%h",
                         imem_req_o, imem_addr_o, RESET_PC + 32'(4 * i));
            end
            checks++;
            if (valid_o !== (i >= 2)) begin
                errors++;
                $display("[TB] FAIL seq_latency: cycle %0d valid_o got %b expected %b", i, valid_o, (i >= 2));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic        fv;
        logic [31:0] fp, fi;
        int          reqs;
        reqs = 0;
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_valid: got %b expected 1", valid_o); end
        stall_i = 1'b1;
        fv = valid_o; fp = pc_o; fi = instr_o;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (imem_req_o) reqs++;
            tick();
            checks++;
            if (valid_o !== fv || pc_o !== fp || instr_o !== fi) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b pc=%h i=%h expected v=%b pc=%h i=%h",
                         valid_o, pc_o, instr_o, fv, fp, fi);
            end
        end
        checks++;
        if (reqs > 2) begin errors++; $display("[TB] FAIL stall_reqs: got %0d requests expected at most 2", reqs); end
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_credit: req got %b expected 0", imem_req_o); end
        stall_i = 1'b0;
        run(8);
    endtask

    task automatic test_redirect();
        logic [31:0] pc_before;
        checks++;
        if (imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL redir_pre_req: got %b expected 1", imem_req_o); end
        tick();
        pc_before     = pc_o;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_req: got %b expected 0", imem_req_o); end
        tick();
        redirect_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || instr_o !== NOP_VAL) begin
            errors++;
            $display("[TB] FAIL redir_bubble: got v=%b i=%h expected v=0 i=%h", valid_o, instr_o, NOP_VAL);
        end
        checks++;
        if (pc_o !== pc_before) begin errors++; $display("[TB] FAIL redir_pc_hold: got %h expected %h", pc_o, pc_before); end
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_target: got req=%b addr=%h expected req=1 addr=00000100", imem_req_o, imem_addr_o);
        end
        imem_valid_i = 1'b1;
        imem_rdata_i = 32'hBAD0_BAD0;
        tick();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL spurious_resp: valid_o got %b expected 0", valid_o); end
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_first: got v=%b pc=%h expected v=1 pc=00000100", valid_o, pc_o);
        end
        run(6);
    endtask

    task automatic test_redirect_stall();
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || instr_o !== NOP_VAL) begin
            errors++;
            $display("[TB] FAIL rs_bubble: got v=%b i=%h expected v=0 i=%h", valid_o, instr_o, NOP_VAL);
        end
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            errors++;
            $display("[TB] FAIL rs_target: got req=%b addr=%h expected req=1 addr=00000200", imem_req_o, imem_addr_o);
        end
        tick();
        stall_i = 1'b0;
        run(6);
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== want[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, want[i]);
            end
            tick();
        end
        run(6);
    endtask

    task automatic test_reset_midstream();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick();
        redirect_i = 1'b0;
        run(5);
        stall_i = 1'b1;
        repeat (4) tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o === 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_pre: got v=%b pc=%h expected v=1 and nonzero pc", valid_o, pc_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || instr_o !== NOP_VAL || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_rst: got v=%b i=%h pc=%h req=%b expected all zero",
                     valid_o, instr_o, pc_o, imem_req_o);
        end
        stall_i      = 1'b0;
        imem_valid_i = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_init: req got %b expected 0", imem_req_o); end
        tick();
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL mid_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
        end
        tick();
        tick();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL mid_first_out: got v=%b pc=%h expected v=1 pc=%h", valid_o, pc_o, RESET_PC);
        end
        run(6);
    endtask

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_valid_i  = 1'b0;
        imem_rdata_i  = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
